// File: rtl/nic_pkg.sv
// rtl/nic_pkg.sv - shared flit types, head-field positions and FSM state types for nic_tx_2ph
package nic_pkg;

  typedef enum logic [1:0] {
    BODY = 2'b00,
    HEAD = 2'b01,
    TAIL = 2'b10
  } flit_type_e;

  // Head flit field positions (each field is a 4-bit nibble)
  localparam int HF_W      = 4;
  localparam int SRC_X_LSB = 12;
  localparam int SRC_Y_LSB = 8;
  localparam int DST_X_LSB = 4;
  localparam int DST_Y_LSB = 0;

  typedef enum logic {
    PK_HEAD,
    PK_BODY
  } pk_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOAD,
    TX_LAUNCH,
    TX_WAIT
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock flit FIFO with extra-MSB pointers for full/empty
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // A pop never bypasses an empty FIFO; a pop on a full FIFO frees the slot for a same-cycle push.
  assign rd_en    = pop && !empty;
  assign wr_en    = push && (!full || rd_en);
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Pointer advance on accepted push/pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (rd_en) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write; contents are only read while non-empty, so no reset is needed
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/nic_tx_2ph.sv
// rtl/nic_tx_2ph.sv - packetizing NIC transmitter driving a 2-phase bundled-data router port
module nic_tx_2ph
  import nic_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int LocationX = 2,
  parameter int LocationY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-3:0] in_data,
  input  logic             in_last,
  input  logic [3:0]       in_dest_x,
  input  logic [3:0]       in_dest_y,
  output logic             req_dw_o,
  output logic [WIDTH-1:0] Data_dw_o,
  input  logic             ack_dw_i,
  output logic             busy,
  output logic             proto_err
);

  pk_state_e        pk_state;
  tx_state_e        tx_state;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_head;
  logic [WIDTH-1:0] head_flit;
  logic [WIDTH-1:0] push_flit;
  logic [1:0]       word_type;
  logic             head_take;
  logic             word_take;
  logic             ack_meta;
  logic             ack_sync;
  logic             ack_prev;

  assign in_ready  = (pk_state == PK_BODY) && !fifo_full;
  assign head_take = (pk_state == PK_HEAD) && in_valid && !fifo_full;
  assign word_take = in_valid && in_ready;
  assign fifo_push = head_take || word_take;
  assign fifo_pop  = (tx_state == TX_LOAD);
  assign busy      = !fifo_empty || (tx_state != TX_IDLE);

  // Build the candidate flit: head from coordinates, otherwise typed payload word
  always_comb begin
    head_flit                           = '0;
    head_flit[WIDTH-1 -: 2]             = HEAD;
    head_flit[SRC_X_LSB +: HF_W]        = HF_W'(LocationX);
    head_flit[SRC_Y_LSB +: HF_W]        = HF_W'(LocationY);
    head_flit[DST_X_LSB +: HF_W]        = in_dest_x;
    head_flit[DST_Y_LSB +: HF_W]        = in_dest_y;
    word_type                           = in_last ? TAIL : BODY;
    push_flit                           = (pk_state == PK_HEAD) ? head_flit : {word_type, in_data};
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_flit),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Packetizer: one head flit per packet, then payload words until the last one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pk_state <= PK_HEAD;
    end else begin
      case (pk_state)
        PK_HEAD: if (head_take) pk_state <= PK_BODY;
        PK_BODY: if (word_take && in_last) pk_state <= PK_HEAD;
        default: pk_state <= PK_HEAD;
      endcase
    end
  end

  // Transmitter: data is registered a full cycle before req toggles and held until the ack phase matches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state  <= TX_IDLE;
      req_dw_o  <= 1'b0;
      Data_dw_o <= '0;
    end else begin
      case (tx_state)
        TX_IDLE:   if (!fifo_empty) tx_state <= TX_LOAD;
        TX_LOAD: begin
          Data_dw_o <= fifo_head;
          tx_state  <= TX_LAUNCH;
        end
        TX_LAUNCH: begin
          req_dw_o <= ~req_dw_o;
          tx_state <= TX_WAIT;
        end
        TX_WAIT: begin
          if (ack_sync == req_dw_o) tx_state <= fifo_empty ? TX_IDLE : TX_LOAD;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Two-flop synchroniser for the asynchronous ack, plus a delayed copy to see its transitions
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_meta <= 1'b0;
      ack_sync <= 1'b0;
      ack_prev <= 1'b0;
    end else begin
      ack_meta <= ack_dw_i;
      ack_sync <= ack_meta;
      ack_prev <= ack_sync;
    end
  end

  // Sticky error: an ack transition is only legitimate while a request is outstanding
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      proto_err <= 1'b0;
    end else if ((ack_sync != ack_prev) && (tx_state != TX_WAIT)) begin
      proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nic_tx_2ph.sv
// tb/tb_nic_tx_2ph.sv - scoreboard bench for nic_tx_2ph with a behavioural router and flit model
module tb_nic_tx_2ph;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int LX    = 2;
  localparam int LY    = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-3:0] in_data;
  logic             in_last;
  logic [3:0]       in_dest_x;
  logic [3:0]       in_dest_y;
  logic             req_dw_o;
  logic [WIDTH-1:0] Data_dw_o;
  logic             ack_dw_i;
  logic             busy;
  logic             proto_err;

  logic             router_ack = 1'b0;
  logic             spur = 1'b0;
  logic             zero_delay = 1'b0;
  logic             hold = 1'b0;
  int               ack_delay = 1;
  int               rcnt = 0;

  int               checks_total = 0;
  int               checks_passed = 0;
  logic [WIDTH-1:0] exp_q[$];
  int               tog_count = 0;
  int               cyc = 0;
  int               words_acc = 0;
  bit               chk_interval = 0;
  int               win_togs = 0;
  int               last_tog_cyc = 0;

  assign ack_dw_i = (zero_delay ? req_dw_o : router_ack) ^ spur;

  always #5 clk = ~clk;

  nic_tx_2ph #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .LocationX (LX),
    .LocationY (LY)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_dest_x (in_dest_x),
    .in_dest_y (in_dest_y),
    .req_dw_o  (req_dw_o),
    .Data_dw_o (Data_dw_o),
    .ack_dw_i  (ack_dw_i),
    .busy      (busy),
    .proto_err (proto_err)
  );

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks_total++;
    if (ok) checks_passed++;
    else $display("FAIL %s: actual=%h required=%h", name, act, req);
  endtask

  function automatic logic [31:0] head_model(input logic [3:0] dx, input logic [3:0] dy);
    return 32'((64'd1 << 30) + (64'(LX) << 12) + (64'(LY) << 8) + (64'(dx) << 4) + 64'(dy));
  endfunction

  function automatic logic [31:0] word_model(input bit last, input logic [WIDTH-3:0] w);
    return 32'(((last ? 64'd2 : 64'd0) << 30) + 64'(w));
  endfunction

  // Router: answers each req phase after ack_delay cycles (or combinationally when zero_delay)
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        router_ack = 1'b0;
        rcnt = 0;
      end else if (zero_delay) begin
        router_ack = req_dw_o;
      end else if (router_ack != req_dw_o && !hold) begin
        rcnt++;
        if (rcnt >= ack_delay) begin
          router_ack = req_dw_o;
          rcnt = 0;
        end
      end
    end
  end

  // Monitor: every req toggle delivers one flit, compared against the scoreboard
  initial begin
    logic             prev_req;
    logic [WIDTH-1:0] prev_data;
    logic [WIDTH-1:0] e;
    prev_req  = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_req  = 1'b0;
        prev_data = '0;
      end else begin
        if (req_dw_o !== prev_req) begin
          tog_count++;
          chk(Data_dw_o == prev_data, "data_setup", Data_dw_o, prev_data);
          chk(busy == 1'b1, "busy_in_flight", 32'(busy), 32'd1);
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_flit", Data_dw_o, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk(Data_dw_o == e, "flit_data", Data_dw_o, e);
          end
          if (chk_interval) begin
            if (win_togs > 0) chk(cyc - last_tog_cyc == 5, "req_interval", 32'(cyc - last_tog_cyc), 32'd5);
            win_togs++;
          end
          last_tog_cyc = cyc;
        end else if (req_dw_o != ack_dw_i) begin
          chk(Data_dw_o == prev_data, "data_hold", Data_dw_o, prev_data);
        end
        prev_req  = req_dw_o;
        prev_data = Data_dw_o;
      end
    end
  end

  // Core-side driver; called right after a falling edge
  task automatic send_packet(input logic [3:0] dx, input logic [3:0] dy, input int n,
                             input logic [WIDTH-3:0] w0, input bit b2b, input bit model);
    logic [WIDTH-3:0] w[$];
    bit acc;
    int i;
    int guard;
    for (int k = 0; k < n; k++) w.push_back(k == 0 ? w0 : (WIDTH-2)'($urandom));
    if (model) begin
      exp_q.push_back(head_model(dx, dy));
      for (int k = 0; k < n; k++) exp_q.push_back(word_model(k == n - 1, w[k]));
    end
    in_dest_x = dx;
    in_dest_y = dy;
    in_data   = w[0];
    in_last   = (n == 1);
    in_valid  = 1'b1;
    chk(in_ready == 1'b0, "head_bubble", 32'(in_ready), 32'd0);
    words_acc = 0;
    i = 0;
    guard = 0;
    while (i < n) begin
      acc = in_ready;
      @(posedge clk);
      if (rst_n && acc) begin
        i++;
        words_acc++;
      end
      @(negedge clk);
      if (!rst_n) begin
        in_valid = 1'b0;
        return;
      end
      if (i < n) begin
        in_data = w[i];
        in_last = (i == n - 1);
      end
      guard++;
      if (guard > 2000) begin
        chk(1'b0, "input_timeout", 32'(i), 32'(n));
        in_valid = 1'b0;
        return;
      end
    end
    if (!b2b) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || busy || req_dw_o != ack_dw_i) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk(g < 3000, "drain_timeout", 32'(g), 32'd3000);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    chk(req_dw_o == 1'b0, {tag, "_req"}, 32'(req_dw_o), 32'd0);
    chk(Data_dw_o == '0, {tag, "_data"}, Data_dw_o, 32'd0);
    chk(in_ready == 1'b0, {tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk(busy == 1'b0, {tag, "_busy"}, 32'(busy), 32'd0);
    chk(proto_err == 1'b0, {tag, "_proto_err"}, 32'(proto_err), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    spur = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    exp_q.delete();
    #1;
    check_reset_values("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    chk(1'b0, "watchdog", 32'(cyc), 32'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    int k;
    int r;
    int t;
    int base;
    logic r0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    in_dest_x = '0;
    in_dest_y = '0;
    rst_n     = 1'b0;
    @(negedge clk);
    check_reset_values("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-word packet, ack 4 cycles after each req
    ack_delay = 4;
    exp_q.push_back(32'h4000_2231);
    exp_q.push_back(32'h8000_1234);
    base = tog_count;
    fork
      send_packet(4'd3, 4'd1, 1, 30'h1234, 1'b0, 1'b0);
      begin
        k = 0;
        while (req_dw_o == 1'b0 && k < 50) begin
          @(negedge clk);
          k++;
        end
        chk(k == 4, "first_latency", 32'(k), 32'd4);
      end
    join
    wait_idle();
    chk(tog_count - base == 2, "single_toggles", 32'(tog_count - base), 32'd2);
    chk(req_dw_o == 1'b0, "single_req_final", 32'(req_dw_o), 32'd0);

    // 4-word packet, router answers instantly: req toggles 5 cycles apart
    zero_delay = 1'b1;
    chk_interval = 1'b1;
    win_togs = 0;
    send_packet(4'($urandom), 4'($urandom), 4, (WIDTH-2)'($urandom), 1'b0, 1'b1);
    wait_idle();
    chk(win_togs == 5, "burst_flits", 32'(win_togs), 32'd5);
    chk_interval = 1'b0;
    zero_delay = 1'b0;

    // Router stall: FIFO fills, in_ready drops, resumes right after the next pop
    hold = 1'b1;
    ack_delay = 2;
    fork
      send_packet(4'($urandom), 4'($urandom), 8, (WIDTH-2)'($urandom), 1'b0, 1'b1);
      begin
        repeat (40) @(negedge clk);
        chk(in_ready == 1'b0, "stall_in_ready", 32'(in_ready), 32'd0);
        chk(words_acc == DEPTH, "stall_buffered", 32'(words_acc), 32'(DEPTH));
        repeat (60) @(negedge clk);
        r0 = req_dw_o;
        hold = 1'b0;
        k = 0;
        r = -1;
        t = -1;
        while (k < 100 && (r < 0 || t < 0)) begin
          @(negedge clk);
          k++;
          if (r < 0 && in_ready) r = k;
          if (t < 0 && req_dw_o != r0) t = k;
        end
        chk(r > 0 && t == r + 1, "ready_resume", 32'(r), 32'(t - 1));
      end
    join
    wait_idle();

    // Back-to-back packets with in_valid held high, destination changes per packet
    ack_delay = 1;
    for (int p = 0; p < 6; p++)
      send_packet(4'($urandom), 4'($urandom), $urandom_range(1, 5), (WIDTH-2)'($urandom), p < 5, 1'b1);
    in_valid = 1'b0;
    wait_idle();

    // Random packets, random gaps and router delays, then with an instant router
    for (int g = 0; g < 2; g++) begin
      zero_delay = (g == 1);
      for (int p = 0; p < 6; p++) begin
        ack_delay = $urandom_range(1, 6);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send_packet(4'($urandom), 4'($urandom), $urandom_range(1, 6), (WIDTH-2)'($urandom), 1'b0, 1'b1);
      end
      wait_idle();
    end
    zero_delay = 1'b0;

    // Spurious ack while idle: sticky error three cycles later, cleared only by reset
    @(negedge clk);
    spur = 1'b1;
    repeat (2) @(negedge clk);
    chk(proto_err == 1'b0, "proto_early", 32'(proto_err), 32'd0);
    @(negedge clk);
    chk(proto_err == 1'b1, "proto_set", 32'(proto_err), 32'd1);
    repeat (10) @(negedge clk);
    chk(proto_err == 1'b1, "proto_sticky", 32'(proto_err), 32'd1);
    pulse_reset();
    repeat (5) @(negedge clk);
    chk(proto_err == 1'b0, "proto_cleared", 32'(proto_err), 32'd0);

    // Reset between flit 2 and flit 3 of a 5-flit packet
    ack_delay = 3;
    base = tog_count;
    fork
      send_packet(4'($urandom), 4'($urandom), 4, (WIDTH-2)'($urandom), 1'b0, 1'b1);
      begin
        k = 0;
        while (tog_count < base + 2 && k < 200) begin
          @(negedge clk);
          k++;
        end
        chk(tog_count == base + 2, "mid_packet_reached", 32'(tog_count - base), 32'd2);
        pulse_reset();
      end
    join
    fork
      send_packet(4'($urandom), 4'($urandom), 2, (WIDTH-2)'($urandom), 1'b0, 1'b1);
      begin
        k = 0;
        while (req_dw_o == 1'b0 && k < 50) begin
          @(negedge clk);
          k++;
        end
        chk(req_dw_o == 1'b1 && Data_dw_o[WIDTH-1 -: 2] == 2'b01, "post_reset_head",
            32'(Data_dw_o[WIDTH-1 -: 2]), 32'd1);
      end
    join
    wait_idle();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
